datapath_unit: RTL and testbench
================================

# datapath_unit

Executes the 32-bit control words and 64-bit constant produced by `control_unit`. It is the consuming end of the controlWord/k interface. The block holds the 32×64 register file, ALU, NZCV status register and program counter, and issues data-memory requests for loads and stores. It sits between `control_unit` and the data-memory port in the LEGv8 single-issue core.

## Interface
- `ADDR_W`, default 64: width of `pc` and `mem_addr`.
- `TIMEOUT`, default 255: memory-ack watchdog limit in cycles. Used only with `DATAPATH_MEM_TIMEOUT_EN`.
- `clock`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `controlWord`, input, 32: control word. Fields: [30:26] DA, [25:21] SA, [20:16] SB, [15:11] FS, [10] WR, [9] WM, [8] EN_MEM, [7] EN_ALU, [6] EN_B, [5] EN_PC, [4:3] PS, [2] SL, [1] SELB, [0] PCSEL. Bit [31] is reserved and ignored.
- `k`, input, 64: constant operand.
- `cw_valid`, input, 1: controlWord and k are valid.
- `cw_ready`, output, 1: the block accepts a word this cycle.
- `mem_req`, output, 1: memory request pending.
- `mem_we`, output, 1: 1 = store, 0 = load.
- `mem_addr`, output, ADDR_W: byte address.
- `mem_wdata`, output, 64: store data.
- `mem_rdata`, input, 64: load data, valid with `mem_ack`.
- `mem_ack`, input, 1: one-cycle completion pulse.
- `pc`, output, ADDR_W: current program counter.
- `status`, output, 4: flags {N,Z,C,V}.
- `err`, output, 1: sticky memory-timeout flag.

## Operation
- Operand A = R[SA].
- Operand B = k when SELB=1, else R[SB].
- R31 always reads 0. Writes to R31 are discarded.
- ALU op select FS[4:2]:
  - 100 add
  - 010 and
  - 001 orr
  - 011 eor
  - 101 lsr by B[5:0]
  - 110 lsl by B[5:0]
  - any other code → result 0
- FS[1]=1 inverts B and sets carry-in to 1 (subtract). FS[0] is reserved and ignored.
- Result bus priority: EN_MEM (load data) > EN_ALU > EN_B (operand B) > EN_PC (pc+4). If no enable is set, the bus is 0.
- R[DA] is written with the result bus when WR=1.
- Flags update only when SL=1 and EN_ALU=1:
  - N = result[63].
  - Z = (result==0).
  - Add/sub: C is the carry-out, V is signed overflow.
  - Logic and shift ops clear C and V.
- PC update on instruction retire:
  - PS=00: hold.
  - PS=01: pc+4.
  - PS=10: pc+(k<<2).
  - PS=11: operand A.
  - PCSEL=1 makes PS=10 conditional. The branch is taken only when B==0; otherwise pc+4.
- All PC arithmetic is modulo 2^ADDR_W.
- State machine, 2 states:
  - READY: `cw_ready`=1. On `cw_valid` with EN_MEM=0: execute and retire in the same cycle, stay in READY.
  - READY: on `cw_valid` with EN_MEM=1: latch DA, WR and next-PC. Drive `mem_req`=1, `mem_we`=WM, `mem_addr`=A+k, `mem_wdata`=R[SB]. Go to MEM.
  - MEM: `cw_ready`=0. Request outputs are held stable. On `mem_ack`: a load with WR=1 writes `mem_rdata` to R[DA]; the PC updates; return to READY.
  - MEM: a `mem_ack` while in READY is ignored.

## Timing
- Non-memory instructions retire in 1 cycle. Register, flag and PC updates are visible the cycle after acceptance.
- Loads and stores take a minimum of 2 cycles: `mem_req` rises the cycle after acceptance and drops the cycle after `mem_ack`.
- The register file is written at the clock edge. A same-cycle read of the written register returns the old value; there is no bypass.
- Reset values:
  - pc=0, status=0, err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cw_ready=1 from the first cycle after reset; state = READY.
  - Registers R0–R30 are cleared to 0.
- Reset asserted in MEM abandons the request: `mem_req` is 0 the next cycle, and no register or PC update occurs.

## Configuration
- `DATAPATH_MEM_TIMEOUT_EN` defined:
  - An 8-bit-minimum counter runs in MEM.
  - After TIMEOUT cycles without `mem_ack`: abort, set `err`=1, skip the register write, advance pc by 4, return to READY.
  - `err` clears only on reset.
- `DATAPATH_MEM_TIMEOUT_EN` undefined: MEM waits indefinitely, and `err` is tied to 0.

## Structure
- Package `datapath_pkg` holds:
  - controlWord field bit positions
  - FS op codes
  - PS codes
  - state enum {READY, MEM}
  - flag bit indices
- One sub-module, `regfile_32x64`: two asynchronous read ports, one synchronous write port, R31 hardwired to zero, synchronous clear on reset.
- ALU, flags, PC logic and the FSM stay in `datapath_unit`.

## Test plan
- Reset, then ADDI (SA=31, k=5, DA=1, SELB=1, FS=10000, WR=1) → R1=5 and pc=4 one cycle later.
- SUBS R2=R1−R1 (FS=10010, SL=1) → R2=0, status=0110 (Z=1, C=1).
- STUR R1 at [R31+16], `mem_ack` 3 cycles later → mem_addr=16, mem_wdata=5, mem_req high for 3 cycles, cw_ready=0 throughout; pc advances on the ack cycle.
- LDUR into R4 with mem_rdata=0xDEAD → R4=0xDEAD. A write with DA=31 leaves R31 reading 0.
- CBZ (PS=10, PCSEL=1, k=3) with B=0 → pc+=12. The same word with B=7 → pc+=4.
- Timeout build with no ack → err=1 after 255 cycles and pc+=4. Reset asserted mid-MEM instead → mem_req=0 next cycle and pc=0.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// datapath_pkg : controlWord field map, ALU/PC codes, FSM states and flag bits
// Revision 1.0
// ---------------------------------------------------------------------------
package datapath_pkg;

  localparam int CW_DA_LSB  = 26;
  localparam int CW_SA_LSB  = 21;
  localparam int CW_SB_LSB  = 16;
  localparam int CW_FS_LSB  = 11;
  localparam int CW_WR      = 10;
  localparam int CW_WM      = 9;
  localparam int CW_EN_MEM  = 8;
  localparam int CW_EN_ALU  = 7;
  localparam int CW_EN_B    = 6;
  localparam int CW_EN_PC   = 5;
  localparam int CW_PS_LSB  = 3;
  localparam int CW_SL      = 2;
  localparam int CW_SELB    = 1;
  localparam int CW_PCSEL   = 0;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b001;
  localparam logic [2:0] OP_EOR = 3'b011;
  localparam logic [2:0] OP_LSR = 3'b101;
  localparam logic [2:0] OP_LSL = 3'b110;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;
  localparam logic [1:0] PS_REG    = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_MEM   = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fs;
    logic       wr;
    logic       wm;
    logic       en_mem;
    logic       en_alu;
    logic       en_b;
    logic       en_pc;
    logic [1:0] ps;
    logic       sl;
    logic       selb;
    logic       pcsel;
  } cw_t;

  function automatic cw_t decode_cw(input logic [31:0] word);
    cw_t c;
    c.da     = word[CW_DA_LSB +: 5];
    c.sa     = word[CW_SA_LSB +: 5];
    c.sb     = word[CW_SB_LSB +: 5];
    c.fs     = word[CW_FS_LSB +: 5];
    c.wr     = word[CW_WR];
    c.wm     = word[CW_WM];
    c.en_mem = word[CW_EN_MEM];
    c.en_alu = word[CW_EN_ALU];
    c.en_b   = word[CW_EN_B];
    c.en_pc  = word[CW_EN_PC];
    c.ps     = word[CW_PS_LSB +: 2];
    c.sl     = word[CW_SL];
    c.selb   = word[CW_SELB];
    c.pcsel  = word[CW_PCSEL];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/datapath_unit_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_32x64 : 2R/1W register file, R31 reads zero, synchronous clear
// Revision 1.0
// ---------------------------------------------------------------------------
module regfile_32x64
  import datapath_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [63:0] ra_data,
  output logic [63:0] rb_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [63:0] wr_data
);

  logic [63:0] rf [32];

  for (genvar i = 0; i < 31; i++) begin : g_reg
    logic [63:0] reg_q;
    logic [63:0] reg_d;

    always_comb begin
      reg_d = reg_q;
      if (wr_en && (wr_addr == 5'(i))) reg_d = wr_data;
    end

    always_ff @(posedge clock) begin
      if (reset) reg_q <= '0;
      else       reg_q <= reg_d;
    end

    assign rf[i] = reg_q;
  end

  assign rf[ZERO_REG] = '0;

  // No write-to-read bypass: a same-cycle read sees the old contents.
  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];

endmodule
`default_nettype wire

// File: rtl/datapath_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// datapath_unit : LEGv8 datapath (regfile, ALU, NZCV, PC, data-memory port)
// Optional memory-ack watchdog: DATAPATH_MEM_TIMEOUT_EN.   Revision 1.0
// ---------------------------------------------------------------------------
module datapath_unit
  import datapath_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       controlWord,
  input  logic [63:0]       k,
  input  logic              cw_valid,
  output logic              cw_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        status,
  output logic              err
);

  cw_t cw;
  assign cw = decode_cw(controlWord);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_lat_q, npc_lat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              wr_lat_q, wr_lat_d;
  logic [4:0]        da_lat_q, da_lat_d;
  logic [3:0]        status_q, status_d;

  logic [63:0]       rf_a, rf_b, op_b, b_eff, alu_res, result;
  logic [64:0]       sum;
  logic              is_arith, alu_c, alu_v;
  logic [ADDR_W-1:0] pc_plus4, npc;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [63:0]       rf_wdata;
  logic              timeout_hit;

  regfile_32x64 u_regfile (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (cw.sa),
    .rb_addr (cw.sb),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .wr_en   (rf_we),
    .wr_addr (rf_waddr),
    .wr_data (rf_wdata)
  );

  always_comb begin
    op_b     = cw.selb ? k : rf_b;
    b_eff    = cw.fs[1] ? ~op_b : op_b;
    sum      = {1'b0, rf_a} + {1'b0, b_eff} + 65'(cw.fs[1]);
    is_arith = 1'b0;
    alu_res  = '0;
    case (cw.fs[4:2])
      OP_ADD: begin
        alu_res  = sum[63:0];
        is_arith = 1'b1;
      end
      OP_AND:  alu_res = rf_a & b_eff;
      OP_ORR:  alu_res = rf_a | b_eff;
      OP_EOR:  alu_res = rf_a ^ b_eff;
      OP_LSR:  alu_res = rf_a >> b_eff[5:0];
      OP_LSL:  alu_res = rf_a << b_eff[5:0];
      default: alu_res = '0;
    endcase
    alu_c = is_arith & sum[64];
    alu_v = is_arith & (rf_a[63] == b_eff[63]) & (sum[63] != rf_a[63]);
  end

  // Load data sits at the top of the result-bus priority but only exists in
  // MEM, so the READY-side bus covers the remaining three sources.
  always_comb begin
    if (cw.en_alu)     result = alu_res;
    else if (cw.en_b)  result = op_b;
    else if (cw.en_pc) result = 64'(pc_plus4);
    else               result = '0;
  end

  always_comb begin
    pc_plus4 = pc_q + ADDR_W'(4);
    case (cw.ps)
      PS_HOLD:   npc = pc_q;
      PS_INC:    npc = pc_plus4;
      PS_BRANCH: npc = (cw.pcsel && (op_b != '0)) ? pc_plus4
                                                   : pc_q + ADDR_W'({k[61:0], 2'b00});
      PS_REG:    npc = ADDR_W'(rf_a);
      default:   npc = pc_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    npc_lat_d   = npc_lat_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    wr_lat_d    = wr_lat_q;
    da_lat_d    = da_lat_q;
    status_d    = status_q;
    rf_we       = 1'b0;
    rf_waddr    = cw.da;
    rf_wdata    = result;
    case (state_q)
      ST_READY: begin
        if (cw_valid) begin
          if (cw.sl && cw.en_alu) begin
            status_d[FLAG_N] = alu_res[63];
            status_d[FLAG_Z] = (alu_res == '0);
            status_d[FLAG_C] = alu_c;
            status_d[FLAG_V] = alu_v;
          end
          if (cw.en_mem) begin
            state_d     = ST_MEM;
            da_lat_d    = cw.da;
            wr_lat_d    = cw.wr;
            npc_lat_d   = npc;
            mem_we_d    = cw.wm;
            mem_addr_d  = ADDR_W'(rf_a + k);
            mem_wdata_d = rf_b;
          end else begin
            rf_we = cw.wr;
            pc_d  = npc;
          end
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          rf_we    = wr_lat_q & ~mem_we_q;
          rf_waddr = da_lat_q;
          rf_wdata = mem_rdata;
          pc_d     = npc_lat_q;
          state_d  = ST_READY;
        end else if (timeout_hit) begin
          pc_d    = pc_plus4;
          state_d = ST_READY;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_READY;
      pc_q        <= '0;
      npc_lat_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      wr_lat_q    <= 1'b0;
      da_lat_q    <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      npc_lat_q   <= npc_lat_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      wr_lat_q    <= wr_lat_d;
      da_lat_q    <= da_lat_d;
      status_q    <= status_d;
    end
  end

`ifdef DATAPATH_MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter holds the number of MEM cycles already spent without an ack.
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if ((state_q == ST_MEM) && !mem_ack) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) timeout_hit = 1'b1;
      else                              cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  logic unused_cw;
  assign unused_cw = controlWord[31] ^ cw.fs[0];

  assign cw_ready  = (state_q == ST_READY);
  assign mem_req   = (state_q == ST_MEM);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign status    = status_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_datapath_unit : directed vectors, memory requests checked by a scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_datapath_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] controlWord = '0;
  logic [63:0] k = '0;
  logic        cw_valid = 1'b0;
  logic        cw_ready;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [63:0] pc;
  logic [3:0]  status;
  logic        err;

  datapath_unit #(.ADDR_W(64), .TIMEOUT(255)) dut (
    .clock       (clock),
    .reset       (reset),
    .controlWord (controlWord),
    .k           (k),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .pc          (pc),
    .status      (status),
    .err         (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_exp_t;

  mem_exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every new memory request is matched against the queue.
  logic req_prev = 1'b0;
  always @(negedge clock) begin
    mem_exp_t e;
    if (mem_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mem_unexpected: got request addr 0x%0h, expected none", mem_addr);
      end else begin
        e = exp_q.pop_front();
        check("mem_we",    64'(mem_we), e.we);
        check("mem_addr",  mem_addr,    e.addr);
        check("mem_wdata", mem_wdata,   e.wdata);
      end
    end
    req_prev = mem_req;
  end

  function automatic logic [31:0] mk(input int da, input int sa, input int sb, input int fs,
                                     input int wr, input int wm, input int en_mem,
                                     input int en_alu, input int en_b, input int en_pc,
                                     input int ps, input int sl, input int selb, input int pcsel);
    return {1'b0, 5'(da), 5'(sa), 5'(sb), 5'(fs), 1'(wr), 1'(wm), 1'(en_mem),
            1'(en_alu), 1'(en_b), 1'(en_pc), 2'(ps), 1'(sl), 1'(selb), 1'(pcsel)};
  endfunction

  function automatic logic [31:0] addi(input int da, input int sa, input int sl);
    return mk(da, sa, 0, 5'b10000, 1, 0, 0, 1, 0, 0, 1, sl, 1, 0);
  endfunction

  function automatic logic [31:0] stur(input int sb, input int sa);
    return mk(0, sa, sb, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
  endfunction

  // Called at a falling edge; returns at the next falling edge after acceptance.
  task automatic issue(input logic [31:0] cw, input logic [63:0] kk);
    controlWord = cw;
    k           = kk;
    cw_valid    = 1'b1;
    @(negedge clock);
    cw_valid    = 1'b0;
  endtask

  // Memory op: mem_req must stay high for lat cycles, ack given in the last one.
  task automatic mem_op(input logic [31:0] cw, input logic [63:0] kk, input int lat,
                        input logic [63:0] rdata, input logic [63:0] pc_hold);
    issue(cw, kk);
    for (int i = 0; i < lat; i++) begin
      check("busy_req",   64'(mem_req),  64'd1);
      check("busy_ready", 64'(cw_ready), 64'd0);
      check("busy_pc",    pc,            pc_hold);
      if (i == lat - 1) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clock);
      mem_ack = 1'b0;
    end
    check("done_req",   64'(mem_req),  64'd0);
    check("done_ready", 64'(cw_ready), 64'd1);
  endtask

  task automatic store_chk(input int sb, input int sa, input logic [63:0] kk,
                           input logic [63:0] exp_addr, input logic [63:0] exp_data,
                           input logic [63:0] pc_hold);
    exp_q.push_back('{64'd1, exp_addr, exp_data});
    mem_op(stur(sb, sa), kk, 1, 64'd0, pc_hold);
    check("store_pc", pc, pc_hold + 64'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_pc",       pc,             64'd0);
    check("rst_status",   64'(status),    64'd0);
    check("rst_err",      64'(err),       64'd0);
    check("rst_req",      64'(mem_req),   64'd0);
    check("rst_we",       64'(mem_we),    64'd0);
    check("rst_addr",     mem_addr,       64'd0);
    check("rst_wdata",    mem_wdata,      64'd0);
    check("rst_ready",    64'(cw_ready),  64'd1);

    issue(addi(1, 31, 0), 64'd5);                                  // R1 = 5
    check("addi_pc", pc, 64'd4);

    issue(mk(2, 1, 1, 5'b10010, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0), 64'd0); // SUBS R2 = R1 - R1
    check("subs_status", 64'(status), 64'b0110);
    check("subs_pc",     pc,          64'd8);

    exp_q.push_back('{64'd1, 64'd16, 64'd5});
    mem_op(stur(1, 31), 64'd16, 3, 64'd0, 64'd8);
    check("stur_pc", pc, 64'd12);

    store_chk(2, 1, 64'd8, 64'd13, 64'd0, 64'd12);                   // R2 == 0

    exp_q.push_back('{64'd0, 64'd5, 64'd0});                        // LDUR R4, [R1]
    mem_op(mk(4, 1, 31, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0), 64'd0, 2, 64'hDEAD, 64'd16);
    check("ldur_pc", pc, 64'd20);
    store_chk(4, 31, 64'd32, 64'd32, 64'hDEAD, 64'd20);

    issue(addi(31, 31, 0), 64'd99);                                // discarded write
    check("r31_pc", pc, 64'd28);
    store_chk(31, 31, 64'd0, 64'd0, 64'd0, 64'd28);

    issue(addi(7, 31, 0), 64'd7);
    check("addi7_pc", pc, 64'd36);
    issue(mk(0, 0, 31, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1), 64'd3);  // CBZ, B = 0
    check("cbz_taken_pc", pc, 64'd48);
    issue(mk(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1), 64'd3);   // CBZ, B = 7
    check("cbz_not_taken_pc", pc, 64'd52);

    issue(addi(8, 31, 0), 64'h7FFF_FFFF_FFFF_FFFF);
    issue(addi(9, 8, 1), 64'd1);                                   // ADDS overflow
    check("adds_v_status", 64'(status), 64'b1001);
    check("adds_v_pc",     pc,          64'd60);

    issue(mk(5, 1, 0, 5'b11000, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0), 64'd2); // LSL R5 = R1 << 2
    check("lsl_status", 64'(status), 64'b0000);
    store_chk(5, 31, 64'd40, 64'd40, 64'd20, 64'd64);

    issue(mk(30, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0), 64'd0);  // R30 = pc + 4
    check("link_pc", pc, 64'd72);
    store_chk(30, 31, 64'd48, 64'd48, 64'd72, 64'd72);

    issue(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0), 64'd0);   // BR R1
    check("br_pc", pc, 64'd5);

    exp_q.push_back('{64'd1, 64'd16, 64'd5});                      // reset during MEM
    issue(stur(1, 31), 64'd16);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_req",   64'(mem_req),  64'd0);
    check("mid_rst_pc",    pc,            64'd0);
    check("mid_rst_ready", 64'(cw_ready), 64'd1);
    store_chk(1, 31, 64'd16, 64'd16, 64'd0, 64'd0);                // regfile cleared

`ifdef DATAPATH_MEM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      exp_q.push_back('{64'd1, 64'd16, 64'd0});
      issue(stur(1, 31), 64'd16);
      while (mem_req && n < 300) begin
        n++;
        @(negedge clock);
      end
      check("timeout_cycles", 64'(n),        64'd255);
      check("timeout_err",    64'(err),      64'd1);
      check("timeout_pc",     pc,            64'd8);
      check("timeout_ready",  64'(cw_ready), 64'd1);
    end
`else
    check("err_tied", 64'(err), 64'd0);
`endif

    @(negedge clock);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
